// File: rtl/seq_detect_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_detect_sched_pkg                                   |
// | Description : Shared types and helpers for the round-robin scheduler |
// |               that time-shares one serial sequence detector.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package seq_detect_sched_pkg;

   // Transaction phases of the scheduler.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_SHIFT = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Wrap an index that may run at most one lap past n back into 0..n-1.
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_sched_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter                                             |
// | Description : Combinational round-robin pick. Search starts at the   |
// |               requester after ptr and wraps; yields one-hot grant    |
// |               and the binary winner index.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arbiter
   import seq_detect_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PTR_W-1:0] idx,
   output logic             valid
);

   // First requester found walking forward from ptr+1 wins.
   always_comb begin
      int j;
      j     = 0;
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = rr_wrap(int'(ptr) + k, N_REQ);
         if (!valid && req[j]) begin
            valid  = 1'b1;
            gnt[j] = 1'b1;
            idx    = PTR_W'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_detect_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_detect_sched                                       |
// | Description : Round-robin scheduler sharing one serial sequence      |
// |               detector. Latches the winner's word, clears the        |
// |               detector, shifts the word MSB-first, counts hits and   |
// |               reports the saturated count with a done pulse.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_detect_sched
   import seq_detect_sched_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*WORD_W-1:0]   data,
   output logic [N_REQ-1:0]          grant,
   output logic                      done,
   output logic [CNT_W-1:0]          match_cnt,
   output logic                      det_rst,
   output logic                      det_inp,
   input  logic                      det_out
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int BIT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);

   state_t              state_q,   state_d;
   logic [N_REQ-1:0]    grant_q,   grant_d;
   logic [WORD_W-1:0]   shift_q,   shift_d;
   logic [PTR_W-1:0]    ptr_q,     ptr_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    match_q,   match_d;
   logic                done_q,    done_d;
   logic                det_rst_q, det_rst_d;
   logic                det_inp_q, det_inp_d;

   logic [N_REQ-1:0]    arb_gnt;
   logic [PTR_W-1:0]    arb_idx;
   logic                arb_valid;
   logic [WORD_W-1:0]   arb_word;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // Saturating increment of the hit counter when the detector fires.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic hit);
      return (hit && (c != CNT_MAX)) ? c + CNT_ONE : c;
   endfunction

   // Mux out the word of the requester currently being granted.
   always_comb begin
      arb_word = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) arb_word = data[i*WORD_W +: WORD_W];
      end
   end

   // Next-state and registered-output logic for the transaction FSM.
   // det_inp/det_rst are computed one cycle ahead so the registered
   // versions line up with the CLEAR and SHIFT phases.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      bit_cnt_d = bit_cnt_q;
      hit_cnt_d = hit_cnt_q;
      match_d   = match_q;
      done_d    = 1'b0;
      det_rst_d = 1'b0;
      det_inp_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d   = ST_CLEAR;
               grant_d   = arb_gnt;
               shift_d   = arb_word;
               ptr_d     = arb_idx;
               det_rst_d = 1'b1;
            end
         end
         ST_CLEAR: begin
            state_d   = ST_SHIFT;
            hit_cnt_d = '0;
            bit_cnt_d = '0;
            det_inp_d = shift_q[WORD_W-1];
            shift_d   = shift_q << 1;
         end
         ST_SHIFT: begin
            // det_out now reflects the previous bit; bit 0 has no predecessor.
            if (bit_cnt_q != '0) hit_cnt_d = sat_add(hit_cnt_q, det_out);
            if (bit_cnt_q == BIT_LAST) begin
               state_d = ST_FLUSH;
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_ONE;
               det_inp_d = shift_q[WORD_W-1];
               shift_d   = shift_q << 1;
            end
         end
         ST_FLUSH: begin
            // Response to the final bit lands here; publish the result.
            match_d = sat_add(hit_cnt_q, det_out);
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         shift_q   <= '0;
         ptr_q     <= PTR_RST;
         bit_cnt_q <= '0;
         hit_cnt_q <= '0;
         match_q   <= '0;
         done_q    <= 1'b0;
         det_rst_q <= 1'b1;
         det_inp_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         bit_cnt_q <= bit_cnt_d;
         hit_cnt_q <= hit_cnt_d;
         match_q   <= match_d;
         done_q    <= done_d;
         det_rst_q <= det_rst_d;
         det_inp_q <= det_inp_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign match_cnt = match_q;
   assign det_rst   = det_rst_q;
   assign det_inp   = det_inp_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_seq_detect_sched                                    |
// | Description : Self-checking bench: timeline reference model, directed|
// |               scenarios and randomized traffic against two DUTs      |
// |               (wide and narrow saturating counters).                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_seq_detect_sched;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = W + 3;   // grant edge to done

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] data = '0;

   logic [N-1:0]   grant,   grant2;
   logic           done,    done2;
   logic [3:0]     match_cnt;
   logic [1:0]     match2;
   logic           det_rst, det_rst2, det_inp, det_inp2;
   logic           det_out = 1'b0, det_out2 = 1'b0;

   int n_checks = 0;
   int n_err    = 0;
   bit started  = 1'b0;

   always #5 clk = ~clk;

   seq_detect_sched #(.N_REQ(N), .WORD_W(W), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant), .done(done),
      .match_cnt(match_cnt), .det_rst(det_rst), .det_inp(det_inp), .det_out(det_out)
   );

   seq_detect_sched #(.N_REQ(N), .WORD_W(W), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant2), .done(done2),
      .match_cnt(match2), .det_rst(det_rst2), .det_inp(det_inp2), .det_out(det_out2)
   );

   // Detector stubs: flag one cycle after every 1 bit, so hits = popcount.
   always @(posedge clk) begin
      det_out  <= det_rst  ? 1'b0 : det_inp;
      det_out2 <= det_rst2 ? 1'b0 : det_inp2;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: transaction timeline ----------------
   bit           m_busy = 1'b0;
   int           m_t    = 0;
   int           m_last = N - 1;
   int           m_win  = 0;
   logic [W-1:0] m_word = '0;
   logic [N-1:0] e_grant = '0;
   logic         e_done = 1'b0, e_rst = 1'b1, e_inp = 1'b0;
   logic [3:0]   e_m4 = '0;
   logic [1:0]   e_m2 = '0;

   always @(posedge clk) begin
      int pc;
      if (rst) begin
         m_busy = 1'b0; m_t = 0; m_last = N - 1; e_m4 = '0; e_m2 = '0;
      end else if (!m_busy) begin
         if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
               if (req[(m_last + k) % N]) begin
                  m_win = (m_last + k) % N;
                  break;
               end
            end
            m_busy = 1'b1; m_t = 1;
            m_word = data[m_win*W +: W];
            m_last = m_win;
         end
      end else begin
         m_t++;
         if (m_t == LAT + 1) begin m_busy = 1'b0; m_t = 0; end
      end
      e_grant = m_busy ? N'(1 << m_win) : '0;
      e_rst   = rst || (m_busy && m_t == 1);
      e_inp   = (m_busy && m_t >= 2 && m_t <= W + 1) ? m_word[W + 1 - m_t] : 1'b0;
      e_done  = m_busy && m_t == LAT;
      if (m_busy && m_t == LAT) begin
         pc   = $countones(m_word);
         e_m4 = (pc > 15) ? 4'd15 : 4'(pc);
         e_m2 = (pc > 3)  ? 2'd3  : 2'(pc);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         chk("grant",     32'(grant),     32'(e_grant));
         chk("grant2",    32'(grant2),    32'(e_grant));
         chk("done",      32'(done),      32'(e_done));
         chk("done2",     32'(done2),     32'(e_done));
         chk("match_cnt", 32'(match_cnt), 32'(e_m4));
         chk("match_sat", 32'(match2),    32'(e_m2));
         chk("det_rst",   32'(det_rst),   32'(e_rst));
         chk("det_inp",   32'(det_inp),   32'(e_inp));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (grant != '0) begin ok = 1'b1; return; end
      end
      n_checks++; n_err++;
      $display("FAIL grant_timeout: no grant within 60 cycles at %0t", $time);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (grant == '0) return;
      end
      n_checks++; n_err++;
      $display("FAIL idle_timeout: grant still %0h after 60 cycles", grant);
   endtask

   // One transaction from requester set r with word w in slot 0.
   // chg: keep req until mid-SHIFT, then drop req and zero the word.
   task automatic run_one(input logic [N-1:0] r, input logic [W-1:0] w, input bit chg,
                          output int lat, output logic [W-1:0] seq);
      bit ok;
      lat = -1; seq = '0;
      data[W-1:0] = w; req = r;
      wait_grant(ok);
      if (!ok) return;
      if (!chg) req = '0;
      for (int c = 2; c <= LAT + 8; c++) begin
         @(negedge clk);
         if (c >= 2 && c <= W + 1) seq = {seq[W-2:0], det_inp};
         if (chg && c == 4) begin req = '0; data[W-1:0] = '0; end
         if (done) begin lat = c; break; end
      end
      wait_idle();
   endtask

   initial begin
      int            lat, ndone, cnt;
      logic [W-1:0]  seq;
      logic [N-1:0]  prev;
      int            order [5];
      bit            ok;

      // Reset
      rst = 1'b1; req = '0;
      @(posedge clk); started = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant",   32'(grant),     32'h0);
      chk("rst_done",    32'(done),      32'h0);
      chk("rst_match",   32'(match_cnt), 32'h0);
      chk("rst_det_rst", 32'(det_rst),   32'h1);
      chk("rst_det_inp", 32'(det_inp),   32'h0);
      rst = 1'b0;

      // Single request, A5
      run_one(4'b0001, 8'hA5, 1'b0, lat, seq);
      chk("single_lat", 32'(lat),       32'd11);
      chk("single_seq", 32'(seq),       32'hA5);
      chk("single_cnt", 32'(match_cnt), 32'd4);

      // Latched word survives data/req changes mid-SHIFT
      run_one(4'b0001, 8'hA5, 1'b1, lat, seq);
      chk("latch_lat", 32'(lat),       32'd11);
      chk("latch_cnt", 32'(match_cnt), 32'd4);

      // Saturation: narrow counter clamps at 3
      run_one(4'b0001, 8'hFF, 1'b0, lat, seq);
      chk("sat_cnt2", 32'(match2),    32'd3);
      chk("sat_cnt4", 32'(match_cnt), 32'd8);

      // Abort during SHIFT bit 3
      data[W-1:0] = 8'h3C; req = 4'b0001;
      wait_grant(ok);
      req = '0;
      repeat (4) @(negedge clk);   // now SHIFT cycle carrying bit 3
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_grant", 32'(grant),     32'h0);
      chk("abort_done",  32'(done),      32'h0);
      chk("abort_match", 32'(match_cnt), 32'h0);
      ndone = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      req = 4'b0010;
      wait_grant(ok);
      req = '0;
      chk("abort_regrant", 32'(grant), 32'b0010);
      wait_idle();

      // Round-robin from reset with all requesting
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      data = {8'h11, 8'h22, 8'h33, 8'h44};
      req = 4'b1111;
      prev = '0; cnt = 0;
      for (int i = 0; i < 100 && cnt < 5; i++) begin
         @(negedge clk);
         chk("rr_onehot", 32'($countones(grant) <= 1), 32'd1);
         if (grant != '0 && prev == '0) begin
            for (int b = 0; b < N; b++) if (grant[b]) order[cnt] = b;
            cnt++;
         end
         prev = grant;
      end
      req = '0;
      chk("rr_count", 32'(cnt), 32'd5);
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(order[i]), 32'(i % N));
      wait_idle();

      // Randomized traffic checked by the model every cycle
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if ($urandom_range(3, 0) == 0) req = N'($urandom);
         if ($urandom_range(1, 0) == 0) data = {$urandom, $urandom} >> 32;
         rst = ($urandom_range(299, 0) == 0);
      end
      rst = 1'b0; req = '0;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that shares one serial sequence-detector FSM (`fsm_beh`-style: `clk`, `rst`, `inp` in; `out` flag) among several requesters. Each granted requester hands over a parallel word. The block clears the detector, shifts the word in MSB-first one bit per cycle, and counts detector hits. It then returns the count with a one-cycle `done` pulse. It sits between requester logic and the detector in the top level, replacing direct testbench drive of `inp`/`rst`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8)
- `WORD_W`, 8: bits shifted per transaction (≥2)
- `CNT_W`, 4: width of hit counter (saturating)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `req` in N_REQ: per-requester request, level
- `data` in N_REQ*WORD_W: requester i word at bits [i*WORD_W +: WORD_W]
- `grant` out N_REQ: one-hot grant, held for the whole transaction
- `done` out 1: one-cycle pulse, result valid
- `match_cnt` out CNT_W: hit count of last transaction, held until next `done`
- `det_rst` out 1: synchronous reset to detector
- `det_inp` out 1: serial bit to detector
- `det_out` in 1: detector match flag (Moore, registered)

## Operation
- States: IDLE, CLEAR, SHIFT, FLUSH, DONE.
- IDLE
  - If any `req`, pick the winner round-robin, starting from the index after the last winner.
  - Latch the winner's `data` word into the shift register.
  - Set `grant` and go to CLEAR.
- CLEAR: assert `det_rst` for 1 cycle. Clear the hit counter and bit counter.
- SHIFT: drive `det_inp` = shift_reg MSB, shift left. Stay WORD_W cycles, bit counter 0..WORD_W-1.
- FLUSH: 1 cycle, `det_inp`=0. Captures the detector response to the last bit.
- DONE: `done`=1, `match_cnt` updated, `grant` still asserted. Next state is IDLE; `grant` drops.
- Hit counting
  - Count `det_out` on the cycle after each shifted bit, i.e. SHIFT cycles 1..WORD_W-1 plus FLUSH: exactly WORD_W samples.
  - Counter saturates at 2^CNT_W-1, no wrap.
- Round-robin pointer updates only on entry to CLEAR. Reset value of the pointer is such that requester 0 has top priority.
- Word is latched at grant; later `req`/`data` changes do not affect the transaction.
- `req` dropping mid-transaction is ignored; the transaction completes and `done` still pulses.
- A requester holding `req` after its `done` re-competes, behind any other pending requesters.
- `det_rst` is also asserted whenever `rst` is high.

## Timing
- Reset values: state IDLE, `grant`=0, `done`=0, `match_cnt`=0, `det_rst`=1 while `rst`, `det_inp`=0, pointer=N_REQ-1.
- Latency from `req` sampled in IDLE to `done`: 1 (CLEAR) + WORD_W + 1 (FLUSH) + 1 = WORD_W+3 cycles after the grant edge.
- Back-to-back throughput: one transaction per WORD_W+4 cycles (IDLE costs 1).
- `rst` mid-transaction: next cycle in IDLE with all outputs at reset values. No `done` is issued for the aborted transaction, and `match_cnt` is cleared to 0.
- Outputs are all registered; no combinational path from `req`/`det_out` to any output.

## Structure
- Shared package: state encoding enum (IDLE/CLEAR/SHIFT/FLUSH/DONE) and the `rr_next` function or localparams for the pointer width (clog2 N_REQ).
- One natural sub-module, `rr_arbiter`: `req`, pointer in; one-hot grant plus winner index out; combinational.
- Shift register, counters and FSM live in `seq_detect_sched`.

## Test plan
Bench uses a detector stub asserting `det_out` one cycle after each `det_inp`=1 (so hits = popcount), plus the real detector in a second run.
- Reset: `rst`=1 for 3 cycles → `grant`=0, `done`=0, `match_cnt`=0, `det_rst`=1, `det_inp`=0.
- Single request: `req`=4'b0001, data0=8'hA5 → `det_inp` sequence 1,0,1,0,0,1,0,1; `done` 11 cycles after grant; `match_cnt`=4.
- Round-robin: `req`=4'b1111 held → grants in order 0,1,2,3,0. Each is one-hot, and no grant overlaps.
- Saturation: CNT_W=2, data=8'hFF → `match_cnt`=3.
- Abort: assert `rst` during SHIFT bit 3 → IDLE next cycle, no `done`, `match_cnt`=0. A new `req`=4'b0010 then gets grant 4'b0010.
- Data/req change after grant: change data0 to 8'h00 and drop `req`[0] during SHIFT → `match_cnt` reflects the latched word (8'hA5 → 4), and `done` still pulses.
